// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder:
//   DEFAULT_WIDTH : default operand / sum width in bits
//   state_t       : sequencer state encoding (2'd3 is unused and decodes to IDLE)
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : serial_adder_pkg

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// Single-bit combinational full adder cell.
// Ports:
//   a, b   : operand bits
//   c      : carry in
//   s      : sum bit
//   c_out  : carry out
// -----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic c_out
);

    assign s     = a ^ b ^ c;
    assign c_out = (a & b) | (a & c) | (b & c);

endmodule : full_adder

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial WIDTH-bit adder. On a start pulse in IDLE it captures a, b and
// cin, then adds one bit pair per clock (LSB first) through a single
// full_adder cell with the carry held in a flop. After WIDTH bit cycles the
// result lands in sum/cout and done pulses for one cycle.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : request, sampled only in IDLE
//   a, b   : operands (WIDTH bits), captured on the accepting edge
//   cin    : carry in, captured on the accepting edge
//   busy   : high while in SHIFT or DONE
//   done   : one-cycle pulse when sum/cout hold a fresh result
//   sum    : last completed sum
//   cout   : carry out of the last completed sum
// -----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_r;
    state_t             state_dec_s;
    state_t             next_state_s;

    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   p_sr;
    logic               cy;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;
    logic               busy_r;
    logic               done_r;

    logic               fa_s_s;
    logic               fa_cout_s;

    // The one and only full adder: LSBs of the shift registers plus the carry flop
    full_adder u_full_adder (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .c     (cy),
        .s     (fa_s_s),
        .c_out (fa_cout_s)
    );

    // Decode the state register; the unused encoding behaves as IDLE
    always_comb begin
        state_dec_s = ST_IDLE;
        case (state_r)
            ST_SHIFT: state_dec_s = ST_SHIFT;
            ST_DONE:  state_dec_s = ST_DONE;
            ST_IDLE:  state_dec_s = ST_IDLE;
            default:  state_dec_s = ST_IDLE;
        endcase
    end

    // Next-state logic
    always_comb begin
        next_state_s = ST_IDLE;
        case (state_dec_s)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_SHIFT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt == CNT_LAST) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_SHIFT;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register with registered busy/done derived from the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s != ST_IDLE);
            done_r  <= (next_state_s == ST_DONE);
        end
    end

    // Operand capture, bit-serial shifting, carry flop and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= {WIDTH{1'b0}};
            b_sr   <= {WIDTH{1'b0}};
            p_sr   <= {WIDTH{1'b0}};
            cy     <= 1'b0;
            cnt    <= {CNT_W{1'b0}};
            sum_r  <= {WIDTH{1'b0}};
            cout_r <= 1'b0;
        end else begin
            case (state_dec_s)
                ST_IDLE: begin
                    if (start) begin
                        a_sr <= a;
                        b_sr <= b;
                        cy   <= cin;
                        cnt  <= {CNT_W{1'b0}};
                        p_sr <= {WIDTH{1'b0}};
                    end else begin
                        cnt  <= cnt;
                    end
                end
                ST_SHIFT: begin
                    a_sr <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr <= {1'b0, b_sr[WIDTH-1:1]};
                    cy   <= fa_cout_s;
                    p_sr <= {fa_s_s, p_sr[WIDTH-1:1]};
                    cnt  <= cnt + CNT_W'(1);
                    // Final bit: the result register takes the completed word
                    // directly so it is valid in the same cycle done is high.
                    if (cnt == CNT_LAST) begin
                        sum_r  <= {fa_s_s, p_sr[WIDTH-1:1]};
                        cout_r <= fa_cout_s;
                    end else begin
                        cout_r <= cout_r;
                    end
                end
                ST_DONE: begin
                    cnt <= cnt;
                end
                default: begin
                    cnt <= cnt;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Scoreboard bench for serial_adder (WIDTH=8). Stimulus pushes the expected
// {cout,sum} computed with plain arithmetic; a monitor pops and compares on
// every done pulse and checks that sum/cout hold between completions.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    logic [W:0] exp_q[$];
    logic [W:0] last_exp = '0;
    bit         cont_mode = 1'b0;
    bit         have_prev = 1'b0;
    int         prev_done_cyc = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // Monitor: compare results on done, check hold between completions
    always @(negedge clk) begin
        logic [W:0] e;
        cyc++;
        if (!rst_n) begin
            check("reset_outputs", {21'd0, busy, done, cout, sum}, 32'd0);
            last_exp  = '0;
            have_prev = 1'b0;
        end else if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("result", {23'd0, cout, sum}, {23'd0, e});
                last_exp = e;
            end
            if (cont_mode) begin
                if (have_prev) check("done_interval", cyc - prev_done_cyc, 32'd10);
                have_prev = 1'b1;
            end else begin
                have_prev = 1'b0;
            end
            prev_done_cyc = cyc;
        end else begin
            check("result_hold", {23'd0, cout, sum}, {23'd0, last_exp});
        end
    end

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        a = x; b = y; cin = c; start = 1'b1;
        exp_q.push_back(model(x, y, c));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (!busy) return;
            @(negedge clk);
        end
        check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        wait_idle();
        issue(x, y, c);
        wait_idle();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Zero operands with busy/done timing: samples taken after E0..E9
        issue(8'h00, 8'h00, 1'b0);
        for (int k = 0; k <= 9; k++) begin
            check("busy_timing", {31'd0, busy}, (k <= 8) ? 32'd1 : 32'd0);
            check("done_timing", {31'd0, done}, (k == 8) ? 32'd1 : 32'd0);
            if (k < 9) @(negedge clk);
        end

        // Carry propagation and carry-in
        run_op(8'hFF, 8'h01, 1'b0);
        run_op(8'hA5, 8'h5A, 1'b1);
        run_op(8'h0F, 8'h01, 1'b0);

        // Start while busy must be ignored
        wait_idle();
        issue(8'h12, 8'h34, 1'b0);
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (12) @(negedge clk);
        check("ignored_start_drained", exp_q.size(), 32'd0);

        // Reset mid-operation between E4 and E5
        issue(8'h80, 8'h7F, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("reset_abort", {21'd0, busy, done, cout, sum}, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        run_op(8'h80, 8'h80, 1'b0);

        // Continuous start with operands changing every cycle
        wait_idle();
        cont_mode = 1'b1;
        start = 1'b1;
        for (int op = 0; op < 50; op++) begin
            for (int c = 0; c < 10; c++) begin
                a   = W'($urandom);
                b   = W'($urandom);
                cin = 1'($urandom);
                if (c == 0) exp_q.push_back(model(a, b, cin));
                @(negedge clk);
            end
        end
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("final_drained", exp_q.size(), 32'd0);
        repeat (3) @(negedge clk);
        cont_mode = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_serial_adder
